// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // A divider of 1 or 2 still needs a one-bit counter.
  function automatic int baud_cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status signals of the UART transmitter.
interface fifo_uart_tx_if;

  logic       tx_en;
  logic       empty;
  logic [7:0] q;
  logic       rdreq;
  logic       txd;
  logic       busy;
  logic       byte_done;

  modport master (
    input  tx_en, empty, q,
    output rdreq, txd, busy, byte_done
  );

  modport slave (
    output tx_en, empty, q,
    input  rdreq, txd, busy, byte_done
  );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: runs 0..BAUD_DIV-1, held at zero while clear is high.
module baud_tick_gen
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int W = baud_cnt_width(BAUD_DIV);
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);
  localparam logic [W-1:0] PRE  = W'(BAUD_DIV - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  // pre_tick lets the consumer register a pulse that lands on the tick cycle.
  assign tick     = (count == LAST);
  assign pre_tick = (count == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a non-show-ahead FIFO and sends each byte as UART 8N1, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input logic            clk,
  input logic            reset,
  fifo_uart_tx_if.master bus
);

  tx_state_t  state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       baud_clear;
  logic       tick;
  logic       pre_tick;
`ifdef UART_PARITY_EN
  logic       parity_bit;
`endif

  // The counter only runs while a bit is on the line, so every bit starts at zero.
  assign baud_clear = (state == IDLE) || (state == RD_REQ) || (state == RD_LATCH);

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shift         <= '0;
      bit_idx       <= '0;
      bus.rdreq     <= 1'b0;
      bus.txd       <= IDLE_LVL;
      bus.busy      <= 1'b0;
      bus.byte_done <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit    <= 1'b0;
`endif
    end else begin
      bus.rdreq     <= 1'b0;
      bus.byte_done <= 1'b0;
      case (state)
        IDLE: begin
          bus.txd  <= IDLE_LVL;
          bus.busy <= 1'b0;
          if (bus.tx_en && !bus.empty) begin
            state     <= RD_REQ;
            bus.rdreq <= 1'b1;
            bus.busy  <= 1'b1;
          end
        end
        RD_REQ: begin
          state <= RD_LATCH;
        end
        RD_LATCH: begin
          shift   <= bus.q;
          bit_idx <= '0;
`ifdef UART_PARITY_EN
          parity_bit <= ^bus.q;
`endif
          state   <= START;
          bus.txd <= START_LVL;
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bus.txd <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state   <= PARITY;
              bus.txd <= parity_bit;
`else
              state   <= STOP;
              bus.txd <= STOP_LVL;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              bus.txd <= shift[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            bus.txd <= STOP_LVL;
          end
        end
`endif
        STOP: begin
          if (pre_tick) begin
            bus.byte_done <= 1'b1;
          end
          if (tick) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          bus.txd <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO model on the read port, frames checked cycle by cycle.
module tb_fifo_uart_tx;

  localparam int DIV = 10;
`ifdef UART_PARITY_EN
  localparam int NSLOTS = 11;
`else
  localparam int NSLOTS = 10;
`endif
  // k counts cycles from the rdreq cycle; the last stop-bit cycle is at LAST_K.
  localparam int LAST_K = NSLOTS * DIV + 1;
  localparam int PERIOD = NSLOTS * DIV + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fifo_uart_tx_if bus ();

  fifo_uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflow = 0;

  assign bus.empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.rdreq) begin
      if (rd_ptr == wr_ptr) begin
        underflow <= underflow + 1;
      end else begin
        bus.q  <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int last_rd = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  function automatic logic slotLevel(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
`ifdef UART_PARITY_EN
    if (slot == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Waits for a fetch, then checks every cycle of the frame plus the idle cycle after it.
  task automatic runFrame(input logic [7:0] data, input int drop_k, input int reset_k,
                          input bit check_period);
    int waited;
    logic [7:0] decoded;
    logic exp_txd;
    int slot;
    waited = 0;
    while (bus.rdreq !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (bus.rdreq !== 1'b1) begin
      checkOutput("rdreq_timeout", 0, 1);
      return;
    end
    if (check_period) checkOutput("period", cyc - last_rd, PERIOD);
    last_rd = cyc;
    decoded = 8'h00;
    for (int k = 0; k <= LAST_K + 1; k++) begin
      if (k > 0) @(negedge clk);
      slot = (k - 2) / DIV;
      exp_txd = (k < 2 || k > LAST_K) ? 1'b1 : slotLevel(data, slot);
      checkOutput("txd", int'(bus.txd), int'(exp_txd));
      checkOutput("busy", int'(bus.busy), int'(k <= LAST_K));
      checkOutput("rdreq", int'(bus.rdreq), int'(k == 0));
      checkOutput("byte_done", int'(bus.byte_done), int'(k == LAST_K));
      if (k >= 2 && slot >= 1 && slot <= 8 && ((k - 2) % DIV) == DIV / 2)
        decoded[slot-1] = bus.txd;
      if (k == drop_k) bus.tx_en = 1'b0;
      if (k == reset_k) begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_txd", int'(bus.txd), 1);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_rdreq", int'(bus.rdreq), 0);
        checkOutput("rst_byte_done", int'(bus.byte_done), 0);
        reset = 1'b0;
        return;
      end
    end
    checkOutput("decoded", int'(decoded), int'(data));
  endtask

  task automatic idleWatch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_rdreq", int'(bus.rdreq), 0);
      checkOutput("idle_busy", int'(bus.busy), 0);
      checkOutput("idle_txd", int'(bus.txd), 1);
    end
  endtask

  logic [7:0] batch [6];
  logic [7:0] r1, r2;

  initial begin
    bus.tx_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", int'(bus.txd), 1);
    checkOutput("reset_rdreq", int'(bus.rdreq), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_byte_done", int'(bus.byte_done), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5);
    bus.tx_en = 1'b1;
    runFrame(8'hA5, -1, -1, 1'b0);

    $display("[TB] back-to-back terminators plus random bytes");
    batch[0] = 8'h37;
    batch[1] = 8'h0D;
    batch[2] = 8'h0A;
    for (int i = 3; i < 6; i++) batch[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) applyStimulus(batch[i]);
    for (int i = 0; i < 6; i++) runFrame(batch[i], -1, -1, i > 0);

    $display("[TB] empty FIFO with tx_en high");
    idleWatch(500);

    $display("[TB] parity bytes 0x07 and 0x03");
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    runFrame(8'h07, -1, -1, 1'b0);
    runFrame(8'h03, -1, -1, 1'b1);

    $display("[TB] tx_en dropped during 0xFF");
    bus.tx_en = 1'b0;
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    applyStimulus(8'hFF);
    applyStimulus(r1);
    applyStimulus(r2);
    bus.tx_en = 1'b1;
    runFrame(8'hFF, 2 + 3 * DIV + DIV / 2, -1, 1'b0);
    idleWatch(300);

    $display("[TB] reset pulse in fifth data bit");
    bus.tx_en = 1'b1;
    runFrame(r1, -1, 2 + 5 * DIV + DIV / 2, 1'b0);
    runFrame(r2, -1, -1, 1'b0);
    idleWatch(50);
    checkOutput("underflow", underflow, 0);
    checkOutput("fifo_drained", rd_ptr, wr_ptr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
